rf_scoreboard: RTL and testbench
================================

// Module: rf_scoreboard
// PURPOSE
//  Parametrised GPR file for the ID stage: NRD combinational read ports, one
//  synchronous write-back port and a per-register pending-write scoreboard.
//  ID issues each writing instruction's destination at decode. W retires it
//  on write-back. The block raises Stall while any source register has an
//  outstanding write, so hazard logic needs no IR decode of later stages.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register index width; depth = 2**ADDR_W
//  NRD     2   number of read ports
//  CNT_W   2   pending-counter width; max outstanding writes/reg = 2**CNT_W-1
// PORTS
//  clk       in   1             clock, rising edge
//  reset     in   1             synchronous, active-high
//  RAddr     in   NRD*ADDR_W    read indices, port k at [k*ADDR_W +: ADDR_W]
//  RUse      in   NRD           port k is a real source operand this cycle
//  RData     out  NRD*DATA_W    read data, port k at [k*DATA_W +: DATA_W]
//  Stall     out  1             a used source has a pending write
//  IssValid  in   1             ID requests to mark IssDst pending
//  IssDst    in   ADDR_W        destination of the issuing instruction
//  IssReady  out  1             issue is accepted this cycle
//  WE        in   1             write-back enable (also retires one pending write)
//  WAddr     in   ADDR_W        write-back index
//  WData     in   DATA_W        write-back data
//  Err       out  1             sticky: retire seen with pending count 0
// BEHAVIOUR
//  - Reset (sync): every register = 0, every counter = 0, Err = 0.
//    Registers only clear by reset; no initial block.
//    Outputs after reset: RData = 0 (bypass aside), Stall = 0, IssReady = 1.
//  - Reg 0: reads return 0. WE to reg 0 writes nothing and retires nothing.
//    Issue to reg 0 is accepted (IssReady = 1) and has no effect.
//    Reg 0 never stalls.
//  - Write: on a rising edge with WE = 1 and WAddr != 0, rf[WAddr] <= WData.
//    Latency 1 cycle to the array.
//  - Read: combinational from the array; see RF_BYPASS_EN.
//  - Counter cnt[r], updated each edge, reset has priority:
//      issue fire (IssValid & IssReady, IssDst = r != 0) : +1
//      retire (WE, WAddr = r != 0)                        : -1
//      issue and retire on the same r, same cycle         : unchanged
//  - IssReady = 0 only when IssDst != 0 and cnt[IssDst] = max with no retire
//    of IssDst this cycle. A simultaneous retire frees the slot, so
//    IssReady = 1. A held-off issue leaves cnt unchanged.
//    ID must hold IssValid and IssDst until IssReady is seen.
//  - Retire with cnt[WAddr] = 0 (WAddr != 0): data is still written, cnt
//    stays 0 (no wrap), and Err <= 1. Err holds until reset.
//  - Stall is the OR over ports k with RUse[k] = 1, RAddr[k] != 0 and
//    pend[k] = 1. Stall is combinational.
//  - Stall and IssReady are independent outputs. Gating an issue on Stall is
//    the caller's job.
//  - Reset mid-operation: all pending state is dropped. Any in-flight WE in
//    the reset cycle is ignored.
// CONFIGURATION
//  RF_BYPASS_EN defined (write-through):
//  - If WE = 1 and WAddr = RAddr[k] != 0, RData[k] = WData in the same cycle.
//  - pend[k] = (cnt[RAddr[k]] - (WE & WAddr == RAddr[k])) != 0, so the last
//    outstanding write resolves the stall in its own write-back cycle.
//  RF_BYPASS_EN undefined:
//  - RData[k] = array value only, so a write is visible the next cycle.
//  - pend[k] = cnt[RAddr[k]] != 0, so Stall holds one cycle longer.
// TESTING
//  1 Reset, then read all 32 regs on both ports.
//    -> RData = 0 every cycle, Stall = 0, IssReady = 1, Err = 0.
//  2 Write $5 = 32'hDEADBEEF, read port0 = 5 in the same cycle.
//    -> 32'hDEADBEEF with RF_BYPASS_EN, old value 0 without it.
//    -> The next cycle reads 32'hDEADBEEF in both builds.
//  3 Issue $8 twice, RUse[1] = 1 with RAddr1 = 8, then retire $8 twice.
//    -> Stall = 1 until the 2nd retire cycle (bypass build) or the cycle
//       after it (no-bypass build).
//  4 CNT_W = 2: issue $3 three times, then a 4th issue.
//    -> IssReady = 0 and cnt stays 3.
//    -> Repeat the 4th issue with a $3 retire in the same cycle:
//       IssReady = 1 and cnt stays 3.
//  5 Retire $9 with cnt = 0 and WData = 7.
//    -> rf[9] = 7, cnt[9] = 0, Err = 1 until reset.
//  6 Write, issue and read reg 0, then pulse reset mid-stream with 4
//    registers pending.
//    -> Reg 0 reads 0 and never stalls.
//    -> After reset: all counters 0, Stall = 0, reads return 0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - GPR file with combinational reads, one write-back port and a pending-write scoreboard
//
// Purpose:
//   Register file for the ID stage. Each register has a small pending-write
//   counter. Decode bumps the counter of an issuing instruction's destination,
//   and write-back decrements it. Stall is raised while any used source
//   operand still has an outstanding write.
//   Optional feature macro: RF_BYPASS_EN. When it is defined, write-back data
//   and the write-back retire are visible to the read ports in the same cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   RAddr     NRD packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   RUse      per-port flag: port k carries a real source operand
//   RData     NRD packed read data, port k at [k*DATA_W +: DATA_W]
//   Stall     a used, non-zero source register has a pending write
//   IssValid  decode requests to mark IssDst pending
//   IssDst    destination register of the issuing instruction
//   IssReady  the issue is accepted this cycle
//   WE        write-back enable; also retires one pending write
//   WAddr     write-back index
//   WData     write-back data
//   Err       sticky: a retire arrived while the pending count was zero
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] RAddr,
  input  logic [NRD-1:0]        RUse,
  output logic [NRD*DATA_W-1:0] RData,
  output logic                  Stall,
  input  logic                  IssValid,
  input  logic [ADDR_W-1:0]     IssDst,
  output logic                  IssReady,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WAddr,
  input  logic [DATA_W-1:0]     WData,
  output logic                  Err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] rf  [DEPTH];
  logic [CNT_W-1:0]  cnt [DEPTH];

  logic           ret;
  logic           iss_fire;
  logic           iss_ret;
  logic [NRD-1:0] stall_vec;

  // Register 0 is hard-wired: writes to it neither store data nor retire.
  assign ret = WE && (WAddr != '0);

  // A retire of the same register in this cycle frees a slot, so a full
  // counter can still accept the issue (the counter then stays unchanged).
  assign iss_ret  = WE && (WAddr == IssDst);
  assign IssReady = !((IssDst != '0) && (cnt[IssDst] == CNT_MAX) && !iss_ret);
  assign iss_fire = IssValid && IssReady && (IssDst != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf[r]  <= '0;
        cnt[r] <= '0;
      end
      Err <= 1'b0;
    end else begin
      if (ret) begin
        rf[WAddr] <= WData;
        if (cnt[WAddr] == '0) begin
          Err <= 1'b1;
        end
      end
      // Issue and retire of the same register cancel out. When they target
      // different registers the two updates never touch the same entry.
      if (iss_fire && !(ret && (WAddr == IssDst))) begin
        cnt[IssDst] <= cnt[IssDst] + 1'b1;
      end
      if (ret && !(iss_fire && (WAddr == IssDst)) && (cnt[WAddr] != '0)) begin
        cnt[WAddr] <= cnt[WAddr] - 1'b1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [CNT_W-1:0]  cnt_eff;

      assign ra = RAddr[k*ADDR_W +: ADDR_W];

`ifdef RF_BYPASS_EN
      logic hit;
      assign hit = WE && (WAddr == ra);
      // The write-back in flight counts as already retired, so the last
      // outstanding write clears the stall in its own cycle.
      assign cnt_eff = cnt[ra] - CNT_W'(hit);
      assign RData[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : (hit ? WData : rf[ra]);
`else
      assign cnt_eff = cnt[ra];
      assign RData[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : rf[ra];
`endif

      assign stall_vec[k] = RUse[k] && (ra != '0) && (cnt_eff != '0);
    end
  endgenerate

  assign Stall = |stall_vec;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - scoreboard-checked directed bench for rf_scoreboard
module tb_rf_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [9:0]  RAddr;
  logic [1:0]  RUse;
  logic [63:0] RData;
  logic        Stall;
  logic        IssValid;
  logic [4:0]  IssDst;
  logic        IssReady;
  logic        WE;
  logic [4:0]  WAddr;
  logic [31:0] WData;
  logic        Err;

  rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NRD(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .RAddr(RAddr), .RUse(RUse), .RData(RData),
    .Stall(Stall), .IssValid(IssValid), .IssDst(IssDst), .IssReady(IssReady),
    .WE(WE), .WAddr(WAddr), .WData(WData), .Err(Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          c0;
    logic [31:0] d0;
    bit          c1;
    logic [31:0] d1;
    logic        st;
    logic        ir;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: one expected entry per sampled cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.c0) chk({e.nm, "/rdata0"}, RData[31:0], e.d0);
      if (e.c1) chk({e.nm, "/rdata1"}, RData[63:32], e.d1);
      chk({e.nm, "/stall"},     {31'd0, Stall},    {31'd0, e.st});
      chk({e.nm, "/iss_ready"}, {31'd0, IssReady}, {31'd0, e.ir});
      chk({e.nm, "/err"},       {31'd0, Err},      {31'd0, e.er});
    end
  end

  task automatic drv(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u,
                     input logic iv, input logic [4:0] id,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    RAddr    = {a1, a0};
    RUse     = u;
    IssValid = iv;
    IssDst   = id;
    WE       = we;
    WAddr    = wa;
    WData    = wd;
  endtask

  task automatic ex(input string nm, input bit c0, input logic [31:0] d0,
                    input bit c1, input logic [31:0] d1,
                    input logic st, input logic ir, input logic er);
    exp_t e;
    e.nm = nm; e.c0 = c0; e.d0 = d0; e.c1 = c1; e.d1 = d1;
    e.st = st; e.ir = ir; e.er = er;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // 1: every register reads 0 after reset on both ports
    for (int r = 0; r < 32; r++) begin
      drv(5'(r), 5'(31 - r), 2'b11, 0, 0, 0, 0, 0);
      ex("t1_reset_read", 1, 0, 1, 0, 0, 1, 0);
      tick();
    end

    // 2: write $5 with a same-cycle read (issued first so the retire is legal)
    drv(5, 0, 2'b00, 1, 5, 0, 0, 0);
    ex("t2_issue5", 1, 0, 0, 0, 0, 1, 0);
    tick();
    drv(5, 0, 2'b01, 0, 0, 1, 5, 32'hDEADBEEF);
    ex("t2_wr_same", 1, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, !BYP, 1, 0);
    tick();
    drv(5, 0, 2'b01, 0, 0, 0, 0, 0);
    ex("t2_wr_next", 1, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    tick();

    // 3: two pending writes to $8 read through port 1
    drv(0, 8, 2'b10, 1, 8, 0, 0, 0);
    ex("t3_iss1", 0, 0, 1, 0, 0, 1, 0);
    tick();
    drv(0, 8, 2'b10, 1, 8, 0, 0, 0);
    ex("t3_iss2", 0, 0, 1, 0, 1, 1, 0);
    tick();
    drv(0, 8, 2'b10, 0, 0, 0, 0, 0);
    ex("t3_wait", 0, 0, 1, 0, 1, 1, 0);
    tick();
    drv(0, 8, 2'b10, 0, 0, 1, 8, 32'h11);
    ex("t3_ret1", 0, 0, 1, BYP ? 32'h11 : 32'h0, 1, 1, 0);
    tick();
    drv(0, 8, 2'b10, 0, 0, 1, 8, 32'h22);
    ex("t3_ret2", 0, 0, 1, BYP ? 32'h22 : 32'h11, !BYP, 1, 0);
    tick();
    drv(0, 8, 2'b10, 0, 0, 0, 0, 0);
    ex("t3_after", 0, 0, 1, 32'h22, 0, 1, 0);
    tick();

    // 4: saturate $3, hold off the 4th issue, then let a retire admit it
    for (int i = 0; i < 3; i++) begin
      drv(3, 0, 2'b01, 1, 3, 0, 0, 0);
      ex("t4_fill", 0, 0, 0, 0, (i != 0), 1, 0);
      tick();
    end
    drv(3, 0, 2'b01, 1, 3, 0, 0, 0);
    ex("t4_full", 1, 0, 0, 0, 1, 0, 0);
    tick();
    drv(3, 0, 2'b01, 1, 3, 1, 3, 32'h33);
    ex("t4_full_ret", 1, BYP ? 32'h33 : 32'h0, 0, 0, 1, 1, 0);
    tick();
    drv(3, 0, 2'b01, 1, 3, 0, 0, 0);
    ex("t4_still_full", 1, 32'h33, 0, 0, 1, 0, 0);
    tick();
    drv(3, 0, 2'b01, 0, 3, 1, 3, 32'h34);
    ex("t4_drain3", 0, 0, 0, 0, 1, 1, 0);
    tick();
    drv(3, 0, 2'b01, 0, 3, 1, 3, 32'h35);
    ex("t4_drain2", 0, 0, 0, 0, 1, 1, 0);
    tick();
    drv(3, 0, 2'b01, 0, 3, 1, 3, 32'h36);
    ex("t4_drain1", 0, 0, 0, 0, !BYP, 1, 0);
    tick();
    drv(3, 0, 2'b01, 0, 3, 0, 0, 0);
    ex("t4_empty", 1, 32'h36, 0, 0, 0, 1, 0);
    tick();

    // 5: retire $9 with no pending write
    drv(9, 0, 2'b00, 0, 0, 1, 9, 32'h7);
    ex("t5_bad_ret", 1, BYP ? 32'h7 : 32'h0, 0, 0, 0, 1, 0);
    tick();
    drv(9, 0, 2'b01, 0, 0, 0, 0, 0);
    ex("t5_err_set", 1, 32'h7, 0, 0, 0, 1, 1);
    tick();
    drv(9, 9, 2'b11, 0, 0, 0, 0, 0);
    ex("t5_err_hold", 1, 32'h7, 1, 32'h7, 0, 1, 1);
    tick();

    // 6: register 0 traffic, then reset with four registers pending
    drv(0, 0, 2'b11, 1, 0, 1, 0, 32'hFFFF_FFFF);
    ex("t6_reg0_same", 1, 0, 1, 0, 0, 1, 1);
    tick();
    drv(0, 0, 2'b11, 0, 0, 0, 0, 0);
    ex("t6_reg0_next", 1, 0, 1, 0, 0, 1, 1);
    tick();
    for (int r = 10; r < 14; r++) begin
      drv(0, 0, 2'b11, 1, 5'(r), 0, 0, 0);
      ex("t6_issue", 1, 0, 1, 0, 0, 1, 1);
      tick();
    end
    drv(10, 11, 2'b11, 0, 0, 0, 0, 0);
    ex("t6_pending", 1, 0, 1, 0, 1, 1, 1);
    tick();
    reset = 1'b1;
    drv(10, 11, 2'b11, 1, 12, 1, 10, 32'hAA);
    tick();
    reset = 1'b0;
    drv(10, 11, 2'b11, 0, 0, 0, 0, 0);
    ex("t6_post_10_11", 1, 0, 1, 0, 0, 1, 0);
    tick();
    drv(12, 13, 2'b11, 0, 13, 0, 0, 0);
    ex("t6_post_12_13", 1, 0, 1, 0, 0, 1, 0);
    tick();
    drv(5, 9, 2'b11, 0, 3, 0, 0, 0);
    ex("t6_post_5_9", 1, 0, 1, 0, 0, 1, 0);
    tick();
    drv(8, 3, 2'b11, 0, 8, 0, 0, 0);
    ex("t6_post_8_3", 1, 0, 1, 0, 0, 1, 0);
    tick();

    drv(0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at time %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
